// File: rtl/store_buffer_pkg.sv
// Shared types, default sizing and pointer-width helper for the posted-write
// store buffer.
package store_buffer_pkg;

  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 32;

  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } sb_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Finds the youngest buffered store whose address equals the load address,
// searching in age order starting at the head so the last hit is the newest.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  localparam int PW   = ptr_w(DEPTH)
) (
  input  logic [AW-1:0]    addrs [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [AW-1:0]    ld_addr,
  output logic             hit,
  output logic [PW-1:0]    idx
);

  logic [PW-1:0] slot;

  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if (valid[slot] && (addrs[slot] == ld_addr)) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of pending stores draining into a single-port
// memory, with same-cycle loads. Define SB_FWD_EN to forward hits from the FIFO.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [AW-1:0]          st_addr,
  input  logic [DW-1:0]          st_data,
  output logic                   st_ready,
  input  logic                   ld_valid,
  input  logic [AW-1:0]          ld_addr,
  output logic [DW-1:0]          ld_data,
  output logic                   ld_ready,
  output logic [AW-1:0]          mem_A,
  output logic [DW-1:0]          mem_WD,
  output logic                   mem_WE,
  input  logic [DW-1:0]          mem_RD,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [PW-1:0]    head, tail, off;
  logic [DEPTH-1:0] valid;
  logic             hit, miss_load, drain, enq;
  logic [PW-1:0]    hit_idx;

  // Slot i is live when its distance from head is below count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PW'(i) - head;
      valid[i] = ({1'b0, off} < count);
    end
  end

  store_buffer_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
    .addrs   (addr_q),
    .valid   (valid),
    .head    (head),
    .ld_addr (ld_addr),
    .hit     (hit),
    .idx     (hit_idx)
  );

  assign empty     = (count == '0);
  assign st_ready  = (count != CW'(DEPTH));
  assign enq       = st_valid && st_ready;
  assign miss_load = ld_valid && !hit;
  assign drain     = !miss_load && !empty;

  assign mem_WE = drain;
  assign mem_WD = drain ? data_q[head] : '0;
  assign mem_A  = miss_load ? ld_addr : (drain ? addr_q[head] : '0);

  // A stalled (non-forwarding) hit also presents FIFO data; ld_ready masks it.
  assign ld_data = !ld_valid ? '0 : (hit ? data_q[hit_idx] : mem_RD);
`ifdef SB_FWD_EN
  assign ld_ready = 1'b1;
`else
  assign ld_ready = !(ld_valid && hit);
`endif

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail] <= st_addr;
      data_q[tail] <= st_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq)   tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      count <= count + CW'(enq) - CW'(drain);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based reference model predicts
// every cycle's outputs; a monitor compares them on the falling edge.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          st_valid, ld_valid;
  logic [AW-1:0] st_addr, ld_addr;
  logic [DW-1:0] st_data;
  logic          st_ready, ld_ready, mem_WE, empty;
  logic [DW-1:0] ld_data, mem_WD, mem_RD;
  logic [AW-1:0] mem_A;
  logic [$clog2(DEPTH):0] count;

  logic [DW-1:0] mem     [256];
  logic [DW-1:0] ref_mem [256];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } st_t;

  typedef struct {
    logic          lv;
    logic          rdy;
    logic [DW-1:0] data;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int            cnt;
    logic          sr;
  } exp_t;

  st_t  sbq   [$];
  exp_t exp_q [$];
  int   checks   = 0;
  int   failures = 0;
  logic rdy;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD),
    .empty(empty), .count(count)
  );

  assign mem_RD = mem[mem_A[7:0]];
  always @(posedge clk) if (mem_WE) mem[mem_A[7:0]] <= mem_WD;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // One datapath cycle: drive inputs, predict outputs, then advance the model.
  task automatic cycle(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic lv, input logic [AW-1:0] la, output logic ready);
    exp_t e;
    int   hit;
    logic miss, drn;
    @(posedge clk); #1;
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la;
    hit = -1;
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (hit < 0 && sbq[i].addr == la) hit = i;
    miss   = lv && (hit < 0);
    e.lv   = lv;
    e.rdy  = 1'b1;
    e.data = '0;
    if (miss) e.data = ref_mem[la[7:0]];
    else if (lv) begin
`ifdef SB_FWD_EN
      e.data = sbq[hit].data;
`else
      e.rdy = 1'b0;
`endif
    end
    drn   = !miss && (sbq.size() > 0);
    e.we  = drn;
    e.a   = miss ? la : (drn ? sbq[0].addr : '0);
    e.wd  = drn ? sbq[0].data : '0;
    e.cnt = sbq.size();
    e.sr  = (sbq.size() < DEPTH);
    exp_q.push_back(e);
    if (drn) begin
      ref_mem[sbq[0].addr[7:0]] = sbq[0].data;
      void'(sbq.pop_front());
    end
    if (sv && e.sr) sbq.push_back('{addr: sa, data: sd});
    ready = e.rdy;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    st_valid = 1'b0; ld_valid = 1'b0;
    sbq.delete();
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_mem_we", 64'(mem_WE), 64'd0);
    chk("rst_mem_a", 64'(mem_A), 64'd0);
    chk("rst_mem_wd", 64'(mem_WD), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd1);
    chk("rst_ld_data", 64'(ld_data), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // Load retried until it completes, as a stalled datapath would.
  task automatic load_until_ready(input logic [AW-1:0] la);
    logic r;
    int   n;
    n = 0;
    r = 1'b0;
    while (!r && n < 2 * DEPTH + 2) begin
      cycle(1'b0, '0, '0, 1'b1, la, r);
      n++;
    end
    checks++;
    if (!r) begin
      failures++;
      $display("FAIL stall_bound actual=stalled required=ready_within_%0d", 2 * DEPTH + 2);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", 64'(count), 64'(e.cnt));
      chk("empty", 64'(empty), 64'(e.cnt == 0));
      chk("st_ready", 64'(st_ready), 64'(e.sr));
      chk("ld_ready", 64'(ld_ready), 64'(e.rdy));
      chk("mem_we", 64'(mem_WE), 64'(e.we));
      chk("mem_a", 64'(mem_A), 64'(e.a));
      chk("mem_wd", 64'(mem_WD), 64'(e.wd));
      if (e.rdy) chk(e.lv ? "ld_data" : "ld_data_idle", 64'(ld_data), 64'(e.data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          lv, sv, stall;
    logic [AW-1:0] la;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000 + i;
      ref_mem[i] = 32'h1000 + i;
    end
    reset = 1'b1;
    st_valid = 1'b0; ld_valid = 1'b0;
    st_addr = '0; ld_addr = '0; st_data = '0;
    do_reset();

    // Fill with stores while miss loads hold the port, then drain freely.
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10 + i, 32'hA0 + i, 1'b1, 32'h80, rdy);
    cycle(1'b1, 32'h30, 32'h55, 1'b1, 32'h81, rdy);
    cycle(1'b1, 32'h30, 32'h55, 1'b0, '0, rdy);
    cycle(1'b1, 32'h30, 32'h55, 1'b0, '0, rdy);
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, '0, rdy);
    load_until_ready(32'h12);
    load_until_ready(32'h30);

    // Two stores to one address, load before they drain.
    cycle(1'b1, 32'h20, 32'h11, 1'b1, 32'h81, rdy);
    cycle(1'b1, 32'h20, 32'h22, 1'b1, 32'h81, rdy);
    load_until_ready(32'h20);
    for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, '0, rdy);

    // Miss-load stream blocks a single pending store.
    cycle(1'b1, 32'h21, 32'h77, 1'b0, '0, rdy);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, '0, 1'b1, 32'h82 + i, rdy);
    cycle(1'b0, '0, '0, 1'b0, '0, rdy);
    load_until_ready(32'h21);

    // Steady enqueue+drain at count 2 wraps both pointers.
    cycle(1'b1, 32'h50, 32'hB0, 1'b1, 32'h90, rdy);
    cycle(1'b1, 32'h51, 32'hB1, 1'b1, 32'h90, rdy);
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'h52 + i, 32'hB2 + i, 1'b0, '0, rdy);
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, '0, 1'b0, '0, rdy);
    for (int i = 0; i < 8; i++) load_until_ready(32'h50 + i);

    // Reset discards pending stores.
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h40 + i, 32'hC0 + i, 1'b1, 32'h91, rdy);
    do_reset();
    for (int i = 0; i < 3; i++) load_until_ready(32'h40 + i);

    // Randomized traffic over a small address window to provoke hits.
    stall = 1'b0;
    la    = '0;
    for (int n = 0; n < 400; n++) begin
      if (!stall) begin
        lv = 1'($urandom_range(0, 1));
        la = 32'($urandom_range(0, 7));
        sv = ($urandom_range(0, 2) != 0);
      end else begin
        lv = 1'b1;
        sv = 1'b0;
      end
      cycle(sv, 32'($urandom_range(0, 7)), $urandom, lv, la, rdy);
      stall = lv && !rdy;
    end
    for (int i = 0; i < DEPTH + 2; i++) cycle(1'b0, '0, '0, 1'b0, '0, rdy);
    for (int i = 0; i < 8; i++) load_until_ready(32'(i));

    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
